wasm_frame_ctrl: RTL and testbench
==================================

# wasm_frame_ctrl

Call/return frame controller for the WASM operand stack. It accepts call and return commands from the decode stage and keeps a LIFO of frame records (return PC, frame base, result arity, caller base). It sequences the operand stack through multi-cycle shift operations: zero-filling locals on call, and on return it captures results, cuts the frame and re-pushes the results. The controller owns the stack's shift/push/call/retu controls whenever `busy`=1; top-level muxing is external.

## Interface
- `ST_WIDTH`, 32, operand stack entry width.
- `ST_LOG2_DEPTH`, 8, log2 of operand stack depth; the top pointer is `ST_LOG2_DEPTH+1` bits.
- `FRAME_LOG2_DEPTH`, 4, log2 of frame LIFO depth.
- `PC_WIDTH`, 16, program counter width.
- `ZERO_LOCALS`, 1. When 1, locals are zero-filled by pushes. When 0, locals are allocated in one `stk_call` shift and are uninitialised.

Ports:
- `clk`  in  1  sole clock. Reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  command ready; high only in IDLE.
- `cmd_is_ret`  in  1  1 = return, 0 = call.
- `call_param_num`  in  4  parameters already on the stack.
- `call_local_num`  in  8  non-parameter locals to allocate.
- `call_result_num`  in  2  result arity, 0..3.
- `call_ret_pc`  in  PC_WIDTH  PC to resume at after return.
- `call_target_pc`  in  PC_WIDTH  callee entry PC.
- `stk_top_pointer`  in  ST_LOG2_DEPTH+1  current stack top.
- `stk_pop_window_a/b/c`  in  ST_WIDTH each  top, top-1, top-2 entries.
- `stk_exceed_push`  in  1  stack overflow flag.
- `stk_shift_vld`  out  1  stack shift strobe.
- `stk_push_num`  out  1  push one entry.
- `stk_push_data`  out  ST_WIDTH  data to push.
- `stk_call`  out  1  allocate-locals strobe.
- `stk_alloc_size`  out  8  locals to allocate.
- `stk_retu`  out  1  cut-to-tag strobe.
- `stk_tag`  out  ST_LOG2_DEPTH  cut target.
- `frame_base`  out  ST_LOG2_DEPTH+1  base of the current frame; the local address is `frame_base + index`.
- `frame_cnt`  out  FRAME_LOG2_DEPTH+1  live frame records.
- `busy`  out  1  controller owns the stack.
- `done_vld`  out  1  one-cycle completion pulse.
- `done_pc`  out  PC_WIDTH  next PC: target on call, return PC on return.
- `fault`  out  1  sticky error.
- `fault_code`  out  3  error cause.

## Operation
- States: IDLE, CALL, ZERO, RET_CAP, RET_CUT, RET_PUSH, DONE, FAULT.
- IDLE: on `cmd_vld & cmd_rdy`, register the command fields and go to CALL or RET_CAP.
- CALL faults and goes to FAULT with no state change in these cases:
  - `frame_cnt == 2^FRAME_LOG2_DEPTH`: code 1.
  - `stk_top_pointer < frame_base + call_param_num`: code 3.
  - base ≥ 2^ST_LOG2_DEPTH: code 4.
- CALL otherwise:
  - Push record {ret_pc, result_num, caller frame_base}.
  - Set `frame_base <= top - param_num`.
  - Next state: if `call_local_num == 0`, go to DONE.
  - Else if `ZERO_LOCALS`, go to ZERO.
  - Else issue `stk_shift_vld=1`, `stk_call=1`, `stk_alloc_size=call_local_num` this cycle and go to DONE.
- ZERO: one push of 0 per cycle (`stk_shift_vld=1`, `stk_push_num=1`, `stk_push_data=0`) for `call_local_num` cycles.
  - If `stk_exceed_push` is high in a push cycle, suppress the strobe and fault with code 4.
- RET_CAP faults and goes to FAULT:
  - `frame_cnt == 0`: code 2.
  - `stk_top_pointer < frame_base + result_num`: code 5.
- RET_CAP otherwise: latch windows a/b/c and pop the record. The record is retained internally until DONE.
- RET_CUT: `stk_shift_vld=1`, `stk_retu=1`, `stk_tag=frame_base[ST_LOG2_DEPTH-1:0]`.
  - If results ≥ 1, also `stk_push_num=1` with the deepest result (r=3→c, r=2→b, r=1→a).
  - Resulting top is base+1, or base when r=0.
- RET_PUSH: push the remaining results, one per cycle, deepest first, ending with a.
- Return DONE: `frame_base <=` caller base from the record.
- DONE: `done_vld=1` for one cycle; `done_pc` is the target (call) or record ret_pc (return); then go to IDLE.
- FAULT: absorbing; `cmd_rdy=0`, `busy=1`, no stack strobes, until `rst`.
- Outside ZERO / RET_CUT / RET_PUSH / non-zeroing CALL, all stack strobes are 0.

## Timing
- Reset values:
  - All outputs 0, except `cmd_rdy`, which is 1 from the first cycle after `rst` falls.
  - `frame_base`=0, `frame_cnt`=0, frame LIFO cleared.
- `rst` mid-sequence aborts immediately to IDLE. Stack state is the stack's own reset responsibility.
- Call latency: accept at cycle 0, CALL at 1; ZERO at cycles 2..1+n; `done_vld` at cycle 2+n. With `ZERO_LOCALS=0` or n=0, `done_vld` is at cycle 2.
- Return latency: accept at 0, RET_CAP at 1, RET_CUT at 2, RET_PUSH at 3..1+r, `done_vld` at cycle 2+r for r≥1 and cycle 3 for r=0.
- `frame_base` updates in the cycle after CALL and in the cycle after return DONE.
- Back-to-back commands: a new command is accepted in the cycle after DONE, never in DONE itself.
- Arithmetic is unsigned on `ST_LOG2_DEPTH+1` bits; base comparisons are done before truncation to `stk_tag`.

## Test plan
- Call: top=5, params=2, locals=3, target=0x40 -> 3 zero pushes in cycles 2–4, top=8, `frame_base`=3, `done_vld` at cycle 5 with `done_pc`=0x40.
- Return: in the frame above, push 11, 22, 33 (top=11), return with r=2 -> stack[3]=22, stack[4]=33, top=5, `frame_base`=0, `done_pc`=ret_pc, `done_vld` at cycle 4.
- Return with r=0 after nested calls -> top=base, and `frame_cnt` decrements each return.
- Overflow: 16 calls then a 17th -> fault code 1, `frame_cnt`=16, `cmd_rdy` stuck at 0.
- Return at `frame_cnt`=0 -> fault 2. Call with params=4 and top=2 -> fault 3.
- `stk_exceed_push` forced during ZERO -> fault 4, strobe suppressed. Then `rst` for 1 cycle -> all outputs at reset values and `cmd_rdy`=1 next cycle.

Source files
------------

// File: rtl/wasm_frame_ctrl.sv
// Call/return frame controller: frame-record LIFO plus operand-stack sequencing for WASM calls/returns.
// Latency: call done at 2+locals (2 with no locals or no zeroing); return done at 2+results (3 with none).
// Backpressure: cmd_rdy only in IDLE; stk_exceed_push during zero-fill faults instead of stalling.
module wasm_frame_ctrl #(
    parameter int ST_WIDTH         = 32,
    parameter int ST_LOG2_DEPTH    = 8,
    parameter int FRAME_LOG2_DEPTH = 4,
    parameter int PC_WIDTH         = 16,
    parameter bit ZERO_LOCALS      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_vld,
    output logic                          cmd_rdy,
    input  logic                          cmd_is_ret,
    input  logic [3:0]                    call_param_num,
    input  logic [7:0]                    call_local_num,
    input  logic [1:0]                    call_result_num,
    input  logic [PC_WIDTH-1:0]           call_ret_pc,
    input  logic [PC_WIDTH-1:0]           call_target_pc,
    input  logic [ST_LOG2_DEPTH:0]        stk_top_pointer,
    input  logic [ST_WIDTH-1:0]           stk_pop_window_a,
    input  logic [ST_WIDTH-1:0]           stk_pop_window_b,
    input  logic [ST_WIDTH-1:0]           stk_pop_window_c,
    input  logic                          stk_exceed_push,
    output logic                          stk_shift_vld,
    output logic                          stk_push_num,
    output logic [ST_WIDTH-1:0]           stk_push_data,
    output logic                          stk_call,
    output logic [7:0]                    stk_alloc_size,
    output logic                          stk_retu,
    output logic [ST_LOG2_DEPTH-1:0]      stk_tag,
    output logic [ST_LOG2_DEPTH:0]        frame_base,
    output logic [FRAME_LOG2_DEPTH:0]     frame_cnt,
    output logic                          busy,
    output logic                          done_vld,
    output logic [PC_WIDTH-1:0]           done_pc,
    output logic                          fault,
    output logic [2:0]                    fault_code
);
    localparam int TW = ST_LOG2_DEPTH + 1;
    localparam int FL = FRAME_LOG2_DEPTH;
    localparam int FW = FRAME_LOG2_DEPTH + 1;
    localparam int FD = 2 ** FRAME_LOG2_DEPTH;
    localparam logic [FW-1:0] FRAME_FULL = FW'(FD);
    localparam logic [TW-1:0] ST_DEPTH   = TW'(2 ** ST_LOG2_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CALL, S_ZERO, S_RET_CAP, S_RET_CUT, S_RET_PUSH, S_DONE, S_FAULT
    } state_t;

    state_t                 r_state, w_next;

    // Registered command
    logic                   r_is_ret;
    logic [3:0]             r_param;
    logic [7:0]             r_local;
    logic [1:0]             r_result;
    logic [PC_WIDTH-1:0]    r_ret_pc;
    logic [PC_WIDTH-1:0]    r_target_pc;
    logic [7:0]             r_cnt;

    // Frame state and LIFO of records
    logic [TW-1:0]          r_frame_base;
    logic [FW-1:0]          r_frame_cnt;
    logic [PC_WIDTH-1:0]    r_lifo_pc   [FD];
    logic [1:0]             r_lifo_res  [FD];
    logic [TW-1:0]          r_lifo_base [FD];

    // Record popped at RET_CAP, kept until return DONE
    logic [PC_WIDTH-1:0]    r_rec_pc;
    logic [1:0]             r_rec_res;
    logic [TW-1:0]          r_rec_base;
    logic [ST_WIDTH-1:0]    r_win_a, r_win_b, r_win_c;
    logic [2:0]             r_fault_code;

    logic [FL-1:0]          w_top_idx;
    logic [TW-1:0]          w_call_base;
    logic [TW-1:0]          w_call_need;
    logic [TW-1:0]          w_ret_need;
    logic                   w_rec_push;
    logic                   w_rec_pop;
    logic                   w_fault_set;
    logic [2:0]             w_fault_code;

    assign w_top_idx   = FL'(r_frame_cnt - FW'(1));
    assign w_call_base = stk_top_pointer - TW'(r_param);
    assign w_call_need = r_frame_base + TW'(r_param);
    assign w_ret_need  = r_frame_base + TW'(r_lifo_res[w_top_idx]);

    assign cmd_rdy    = (r_state == S_IDLE) && !rst;
    assign busy       = (r_state != S_IDLE);
    assign fault      = (r_state == S_FAULT);
    assign fault_code = r_fault_code;
    assign frame_base = r_frame_base;
    assign frame_cnt  = r_frame_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state, stack strobes and completion outputs
    always_comb begin
        w_next         = r_state;
        stk_shift_vld  = 1'b0;
        stk_push_num   = 1'b0;
        stk_push_data  = '0;
        stk_call       = 1'b0;
        stk_alloc_size = '0;
        stk_retu       = 1'b0;
        stk_tag        = '0;
        done_vld       = 1'b0;
        done_pc        = '0;
        w_rec_push     = 1'b0;
        w_rec_pop      = 1'b0;
        w_fault_set    = 1'b0;
        w_fault_code   = '0;
        case (r_state)
            S_IDLE: begin
                if (cmd_vld) w_next = cmd_is_ret ? S_RET_CAP : S_CALL;
            end
            S_CALL: begin
                if (r_frame_cnt == FRAME_FULL) begin
                    w_fault_set = 1'b1; w_fault_code = 3'd1; w_next = S_FAULT;
                end else if (stk_top_pointer < w_call_need) begin
                    w_fault_set = 1'b1; w_fault_code = 3'd3; w_next = S_FAULT;
                end else if (w_call_base >= ST_DEPTH) begin
                    w_fault_set = 1'b1; w_fault_code = 3'd4; w_next = S_FAULT;
                end else begin
                    w_rec_push = 1'b1;
                    if (r_local == 8'd0) begin
                        w_next = S_DONE;
                    end else if (ZERO_LOCALS) begin
                        w_next = S_ZERO;
                    end else begin
                        stk_shift_vld  = 1'b1;
                        stk_call       = 1'b1;
                        stk_alloc_size = r_local;
                        w_next         = S_DONE;
                    end
                end
            end
            S_ZERO: begin
                if (stk_exceed_push) begin
                    w_fault_set = 1'b1; w_fault_code = 3'd4; w_next = S_FAULT;
                end else begin
                    stk_shift_vld = 1'b1;
                    stk_push_num  = 1'b1;
                    if (r_cnt == r_local - 8'd1) w_next = S_DONE;
                end
            end
            S_RET_CAP: begin
                if (r_frame_cnt == '0) begin
                    w_fault_set = 1'b1; w_fault_code = 3'd2; w_next = S_FAULT;
                end else if (stk_top_pointer < w_ret_need) begin
                    w_fault_set = 1'b1; w_fault_code = 3'd5; w_next = S_FAULT;
                end else begin
                    w_rec_pop = 1'b1;
                    w_next    = S_RET_CUT;
                end
            end
            S_RET_CUT: begin
                // Cut to the frame base and, in the same strobe, push the deepest result
                stk_shift_vld = 1'b1;
                stk_retu      = 1'b1;
                stk_tag       = r_frame_base[ST_LOG2_DEPTH-1:0];
                stk_push_num  = (r_rec_res != 2'd0);
                case (r_rec_res)
                    2'd3:    stk_push_data = r_win_c;
                    2'd2:    stk_push_data = r_win_b;
                    2'd1:    stk_push_data = r_win_a;
                    default: stk_push_data = '0;
                endcase
                w_next = (r_rec_res > 2'd1) ? S_RET_PUSH : S_DONE;
            end
            S_RET_PUSH: begin
                // r_cnt = results still to push; window a is always the last one
                stk_shift_vld = 1'b1;
                stk_push_num  = 1'b1;
                stk_push_data = (r_cnt == 8'd2) ? r_win_b : r_win_a;
                if (r_cnt == 8'd1) w_next = S_DONE;
            end
            S_DONE: begin
                done_vld = 1'b1;
                done_pc  = r_is_ret ? r_rec_pc : r_target_pc;
                w_next   = S_IDLE;
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command capture, frame LIFO, counters and fault cause
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_ret     <= 1'b0;
            r_param      <= '0;
            r_local      <= '0;
            r_result     <= '0;
            r_ret_pc     <= '0;
            r_target_pc  <= '0;
            r_cnt        <= '0;
            r_frame_base <= '0;
            r_frame_cnt  <= '0;
            r_rec_pc     <= '0;
            r_rec_res    <= '0;
            r_rec_base   <= '0;
            r_win_a      <= '0;
            r_win_b      <= '0;
            r_win_c      <= '0;
            r_fault_code <= '0;
            for (int i = 0; i < FD; i++) begin
                r_lifo_pc[i]   <= '0;
                r_lifo_res[i]  <= '0;
                r_lifo_base[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_vld) begin
                        r_is_ret    <= cmd_is_ret;
                        r_param     <= call_param_num;
                        r_local     <= call_local_num;
                        r_result    <= call_result_num;
                        r_ret_pc    <= call_ret_pc;
                        r_target_pc <= call_target_pc;
                        r_cnt       <= '0;
                    end
                end
                S_CALL: begin
                    if (w_rec_push) begin
                        r_lifo_pc[r_frame_cnt[FL-1:0]]   <= r_ret_pc;
                        r_lifo_res[r_frame_cnt[FL-1:0]]  <= r_result;
                        r_lifo_base[r_frame_cnt[FL-1:0]] <= r_frame_base;
                        r_frame_cnt  <= r_frame_cnt + FW'(1);
                        r_frame_base <= w_call_base;
                    end
                end
                S_ZERO: begin
                    if (stk_push_num) r_cnt <= r_cnt + 8'd1;
                end
                S_RET_CAP: begin
                    if (w_rec_pop) begin
                        r_rec_pc    <= r_lifo_pc[w_top_idx];
                        r_rec_res   <= r_lifo_res[w_top_idx];
                        r_rec_base  <= r_lifo_base[w_top_idx];
                        r_win_a     <= stk_pop_window_a;
                        r_win_b     <= stk_pop_window_b;
                        r_win_c     <= stk_pop_window_c;
                        r_frame_cnt <= r_frame_cnt - FW'(1);
                    end
                end
                S_RET_CUT:  r_cnt <= 8'(r_rec_res) - 8'd1;
                S_RET_PUSH: r_cnt <= r_cnt - 8'd1;
                S_DONE: begin
                    if (r_is_ret) r_frame_base <= r_rec_base;
                end
                default: ;
            endcase
            if (w_fault_set) r_fault_code <= w_fault_code;
        end
    end
endmodule

// File: tb/tb_wasm_frame_ctrl.sv
// Bench for wasm_frame_ctrl: an operand-stack emulator driven by the DUT strobes, plus a
// frame/stack reference model built from call/return rules (queues of frames and values).
// Randomized nested calls/returns, the documented scenarios, and every fault cause.
module tb_wasm_frame_ctrl;
    logic        clk, rst;
    logic        cmd_vld, cmd_rdy, cmd_is_ret;
    logic [3:0]  call_param_num;
    logic [7:0]  call_local_num;
    logic [1:0]  call_result_num;
    logic [15:0] call_ret_pc, call_target_pc;
    logic [8:0]  stk_top_pointer;
    logic [31:0] stk_pop_window_a, stk_pop_window_b, stk_pop_window_c;
    logic        stk_exceed_push;
    logic        stk_shift_vld, stk_push_num, stk_call, stk_retu;
    logic [31:0] stk_push_data;
    logic [7:0]  stk_alloc_size, stk_tag;
    logic [8:0]  frame_base;
    logic [4:0]  frame_cnt;
    logic        busy, done_vld, fault;
    logic [15:0] done_pc;
    logic [2:0]  fault_code;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wasm_frame_ctrl dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_is_ret(cmd_is_ret),
        .call_param_num(call_param_num), .call_local_num(call_local_num),
        .call_result_num(call_result_num), .call_ret_pc(call_ret_pc),
        .call_target_pc(call_target_pc), .stk_top_pointer(stk_top_pointer),
        .stk_pop_window_a(stk_pop_window_a), .stk_pop_window_b(stk_pop_window_b),
        .stk_pop_window_c(stk_pop_window_c), .stk_exceed_push(stk_exceed_push),
        .stk_shift_vld(stk_shift_vld), .stk_push_num(stk_push_num), .stk_push_data(stk_push_data),
        .stk_call(stk_call), .stk_alloc_size(stk_alloc_size), .stk_retu(stk_retu), .stk_tag(stk_tag),
        .frame_base(frame_base), .frame_cnt(frame_cnt), .busy(busy), .done_vld(done_vld),
        .done_pc(done_pc), .fault(fault), .fault_code(fault_code)
    );

    // ---------------- operand stack emulator (environment) ----------------
    logic [31:0] em_mem [256];
    logic [8:0]  em_top, em_nt;
    logic        em_clr, em_ld_vld, em_we;
    logic [31:0] em_ld_dat, em_wd;
    logic [7:0]  em_wi;

    assign stk_top_pointer  = em_top;
    assign stk_pop_window_a = em_mem[em_top[7:0] - 8'd1];
    assign stk_pop_window_b = em_mem[em_top[7:0] - 8'd2];
    assign stk_pop_window_c = em_mem[em_top[7:0] - 8'd3];

    always_comb begin
        em_nt = em_top; em_we = 1'b0; em_wi = '0; em_wd = '0;
        if (em_clr) begin
            em_nt = '0;
        end else if (em_ld_vld) begin
            em_we = 1'b1; em_wi = em_top[7:0]; em_wd = em_ld_dat; em_nt = em_top + 9'd1;
        end else if (stk_shift_vld) begin
            if (stk_retu) em_nt = {1'b0, stk_tag};
            if (stk_call) em_nt = em_nt + 9'(stk_alloc_size);
            if (stk_push_num) begin
                em_we = 1'b1; em_wi = em_nt[7:0]; em_wd = stk_push_data; em_nt = em_nt + 9'd1;
            end
        end
    end

    always @(posedge clk) begin
        em_top <= em_nt;
        if (em_we) em_mem[em_wi] <= em_wd;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int ret_pc;
        int res;
        int cbase;
    } frec_t;
    logic [31:0] mstk[$];
    frec_t       mfr[$];
    int          mbase;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; em_clr = 1'b1; cmd_vld = 1'b0; stk_exceed_push = 1'b0;
        tick(); tick();
        rst = 1'b0; em_clr = 1'b0;
        tick();
        mstk.delete(); mfr.delete(); mbase = 0;
    endtask

    task automatic preload(input logic [31:0] v);
        em_ld_vld = 1'b1; em_ld_dat = v;
        tick();
        em_ld_vld = 1'b0;
        mstk.push_back(v);
    endtask

    task automatic drive_cmd(input bit is_ret, input int p, input int l, input int r,
                             input int rpc, input int tpc);
        cmd_vld = 1'b1; cmd_is_ret = is_ret;
        call_param_num = 4'(p); call_local_num = 8'(l); call_result_num = 2'(r);
        call_ret_pc = 16'(rpc); call_target_pc = 16'(tpc);
    endtask

    // Call: expect zero-fill of l locals, base = top - p, done at 2+l (2 when l==0)
    task automatic run_call(input int p, input int l, input int r, input int tpc, input int rpc);
        int old_top, exp_base, exp_cyc, cyc, dcyc, zeros, dpc;
        bit seen, rdy_done;
        frec_t f;
        old_top = mstk.size(); exp_base = old_top - p;
        exp_cyc = (l == 0) ? 2 : 2 + l;
        checks++;
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL call_rdy: got %0b want 1", cmd_rdy); end
        drive_cmd(1'b0, p, l, r, rpc, tpc);
        tick();
        cmd_vld = 1'b0;
        cyc = 1; seen = 0; zeros = 0; dcyc = 0; dpc = 0; rdy_done = 1'b0;
        while (!seen && cyc < 300) begin
            if (done_vld === 1'b1) begin
                seen = 1; dcyc = cyc; dpc = int'(done_pc); rdy_done = cmd_rdy;
            end else begin
                if (stk_shift_vld && stk_push_num && stk_push_data == 32'd0) zeros++;
                tick(); cyc++;
            end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL call_timeout: no done_vld within %0d cycles", cyc);
        end else begin
            checks += 3;
            if (dcyc != exp_cyc) begin errors++; $display("FAIL call_latency: got %0d want %0d", dcyc, exp_cyc); end
            if (dpc != (tpc & 16'hffff)) begin errors++; $display("FAIL call_done_pc: got %0h want %0h", dpc, tpc); end
            if (rdy_done !== 1'b0) begin errors++; $display("FAIL call_rdy_in_done: got %0b want 0", rdy_done); end
        end
        tick();
        checks += 4;
        if (frame_base !== 9'(exp_base)) begin errors++; $display("FAIL call_base: got %0d want %0d", frame_base, exp_base); end
        if (frame_cnt !== 5'(mfr.size() + 1)) begin errors++; $display("FAIL call_frame_cnt: got %0d want %0d", frame_cnt, mfr.size() + 1); end
        if (em_top !== 9'(old_top + l)) begin errors++; $display("FAIL call_top: got %0d want %0d", em_top, old_top + l); end
        if (zeros != l) begin errors++; $display("FAIL call_zero_pushes: got %0d want %0d", zeros, l); end
        for (int i = 0; i < l; i++) begin
            checks++;
            if (em_mem[8'(old_top + i)] !== 32'd0) begin
                errors++; $display("FAIL call_local_zero[%0d]: got %0h want 0", old_top + i, em_mem[8'(old_top + i)]);
            end
        end
        f.ret_pc = rpc & 16'hffff; f.res = r; f.cbase = mbase;
        mfr.push_back(f); mbase = exp_base;
        for (int i = 0; i < l; i++) mstk.push_back(32'd0);
    endtask

    // Return: results = top r values, stack cut to base and results re-pushed in order
    task automatic run_ret();
        frec_t f;
        logic [31:0] res[$];
        int exp_cyc, cyc, dcyc, dpc, n;
        bit seen;
        f = mfr[mfr.size() - 1];
        n = mstk.size();
        for (int i = n - f.res; i < n; i++) res.push_back(mstk[i]);
        exp_cyc = (f.res == 0) ? 3 : 2 + f.res;
        drive_cmd(1'b1, 0, 0, f.res, 0, 0);
        tick();
        cmd_vld = 1'b0;
        cyc = 1; seen = 0; dcyc = 0; dpc = 0;
        while (!seen && cyc < 300) begin
            if (done_vld === 1'b1) begin seen = 1; dcyc = cyc; dpc = int'(done_pc); end
            else begin tick(); cyc++; end
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL ret_timeout: no done_vld within %0d cycles", cyc);
        end else begin
            checks += 2;
            if (dcyc != exp_cyc) begin errors++; $display("FAIL ret_latency: got %0d want %0d", dcyc, exp_cyc); end
            if (dpc != f.ret_pc) begin errors++; $display("FAIL ret_done_pc: got %0h want %0h", dpc, f.ret_pc); end
        end
        tick();
        checks += 3;
        if (frame_base !== 9'(f.cbase)) begin errors++; $display("FAIL ret_base: got %0d want %0d", frame_base, f.cbase); end
        if (frame_cnt !== 5'(mfr.size() - 1)) begin errors++; $display("FAIL ret_frame_cnt: got %0d want %0d", frame_cnt, mfr.size() - 1); end
        if (em_top !== 9'(mbase + f.res)) begin errors++; $display("FAIL ret_top: got %0d want %0d", em_top, mbase + f.res); end
        for (int i = 0; i < f.res; i++) begin
            checks++;
            if (em_mem[8'(mbase + i)] !== res[i]) begin
                errors++; $display("FAIL ret_result[%0d]: got %0h want %0h", mbase + i, em_mem[8'(mbase + i)], res[i]);
            end
        end
        while (mstk.size() > mbase) void'(mstk.pop_back());
        for (int i = 0; i < f.res; i++) mstk.push_back(res[i]);
        mbase = f.cbase;
        void'(mfr.pop_back());
    endtask

    // Issue a command that must fault with the given cause and leave the controller stuck
    task automatic run_fault(input bit is_ret, input int p, input int r, input int code,
                             input int exp_cnt, input string nm);
        int cyc;
        bit strobe;
        drive_cmd(is_ret, p, 0, r, 16'h0bad, 16'h0bee);
        tick();
        cmd_vld = 1'b0;
        cyc = 0;
        while (fault !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        checks += 4;
        if (fault !== 1'b1) begin errors++; $display("FAIL %s_fault: got %0b want 1", nm, fault); end
        if (fault_code !== 3'(code)) begin errors++; $display("FAIL %s_code: got %0d want %0d", nm, fault_code, code); end
        if (frame_cnt !== 5'(exp_cnt)) begin errors++; $display("FAIL %s_frame_cnt: got %0d want %0d", nm, frame_cnt, exp_cnt); end
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %0b want 1", nm, busy); end
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cmd_rdy !== 1'b0 || stk_shift_vld !== 1'b0 || done_vld !== 1'b0) strobe = 1'b1;
        end
        checks++;
        if (strobe) begin errors++; $display("FAIL %s_stuck: got activity after fault want none", nm); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; em_clr = 1'b1;
        tick(); tick();
        checks += 7;
        if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_in_rst: got %0b want 0", cmd_rdy); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (done_vld !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_vld); end
        if (fault !== 1'b0 || fault_code !== 3'd0) begin errors++; $display("FAIL reset_fault: got %0b/%0d want 0/0", fault, fault_code); end
        if (frame_cnt !== 5'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        if (frame_base !== 9'd0) begin errors++; $display("FAIL reset_base: got %0d want 0", frame_base); end
        if (stk_shift_vld !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", stk_shift_vld); end
        rst = 1'b0; em_clr = 1'b0;
        tick();
        checks++;
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_after: got %0b want 1", cmd_rdy); end
        mstk.delete(); mfr.delete(); mbase = 0;
    endtask

    task automatic test_call_return();
        do_reset();
        for (int i = 0; i < 5; i++) preload($urandom);
        run_call(2, 3, 2, 16'h0040, 16'h1234);
        preload(32'd11); preload(32'd22); preload(32'd33);
        run_ret();
    endtask

    task automatic test_nested_r0();
        do_reset();
        for (int i = 0; i < 3; i++) preload($urandom);
        run_call(1, 2, 0, 16'h0100, 16'h0011);
        preload($urandom);
        run_call(1, 0, 0, 16'h0200, 16'h0022);
        preload($urandom); preload($urandom);
        run_ret();
        run_ret();
    endtask

    task automatic test_random();
        int p, l, r, avail;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if (mfr.size() == 0 || (mfr.size() < 16 && $urandom_range(0, 1) == 1)) begin
                for (int k = $urandom_range(0, 3); k > 0; k--) preload($urandom);
                avail = mstk.size() - mbase;
                p = $urandom_range(0, (avail > 15) ? 15 : avail);
                l = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5);
                r = $urandom_range(0, 3);
                run_call(p, l, r, $urandom_range(0, 16'hffff), $urandom_range(0, 16'hffff));
            end else begin
                while (mstk.size() < mbase + mfr[mfr.size() - 1].res) preload($urandom);
                for (int k = $urandom_range(0, 2); k > 0; k--) preload($urandom);
                run_ret();
            end
        end
        while (mfr.size() > 0) begin
            while (mstk.size() < mbase + mfr[mfr.size() - 1].res) preload($urandom);
            run_ret();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) run_call(0, 0, 0, 16'h0300 + i, 16'h0400 + i);
        run_fault(1'b0, 0, 0, 1, 16, "overflow");
    endtask

    task automatic test_faults();
        do_reset();
        run_fault(1'b1, 0, 0, 2, 0, "ret_empty");
        do_reset();
        preload(32'h5); preload(32'h6);
        run_fault(1'b0, 4, 0, 3, 0, "few_params");
        do_reset();
        run_call(0, 0, 3, 16'h0500, 16'h0600);
        preload(32'h7);
        run_fault(1'b1, 0, 3, 5, 1, "few_results");
    endtask

    task automatic test_exceed_and_reset();
        do_reset();
        preload(32'h1); preload(32'h2);
        stk_exceed_push = 1'b1;
        drive_cmd(1'b0, 1, 4, 0, 16'h0700, 16'h0800);
        tick();                  // cycle 1: CALL
        cmd_vld = 1'b0;
        tick();                  // cycle 2: first zero-fill slot
        checks++;
        if (stk_shift_vld !== 1'b0 || stk_push_num !== 1'b0) begin
            errors++; $display("FAIL exceed_strobe: got shift=%0b push=%0b want 0/0", stk_shift_vld, stk_push_num);
        end
        tick();
        checks += 3;
        if (fault !== 1'b1) begin errors++; $display("FAIL exceed_fault: got %0b want 1", fault); end
        if (fault_code !== 3'd4) begin errors++; $display("FAIL exceed_code: got %0d want 4", fault_code); end
        if (em_top !== 9'd2) begin errors++; $display("FAIL exceed_top: got %0d want 2", em_top); end
        stk_exceed_push = 1'b0;
        rst = 1'b1;
        tick();
        checks += 4;
        if (fault !== 1'b0 || fault_code !== 3'd0) begin errors++; $display("FAIL rst_fault_clear: got %0b/%0d want 0/0", fault, fault_code); end
        if (busy !== 1'b0 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_busy_rdy: got %0b/%0b want 0/0", busy, cmd_rdy); end
        if (frame_cnt !== 5'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        if (frame_base !== 9'd0) begin errors++; $display("FAIL rst_base: got %0d want 0", frame_base); end
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy_next: got %0b want 1", cmd_rdy); end
    endtask

    initial begin
        rst = 1'b1; em_clr = 1'b1; em_ld_vld = 1'b0; em_ld_dat = '0;
        cmd_vld = 1'b0; cmd_is_ret = 1'b0; call_param_num = '0; call_local_num = '0;
        call_result_num = '0; call_ret_pc = '0; call_target_pc = '0; stk_exceed_push = 1'b0;
        mbase = 0;
        @(negedge clk);
        test_reset();
        test_call_return();
        test_nested_r0();
        test_random();
        test_overflow();
        test_faults();
        test_exceed_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
